// File: rtl/custom_bitop_unit_if.sv
// Request/response bundle between the core and the bit-manipulation unit.
// Valid/ready contract: a request is accepted on a rising edge where start=1 and the unit is idle or done; done marks a valid result for exactly one cycle.
interface custom_bitop_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] src_a;
    logic             flush;
    logic             busy;
    logic             done;
    logic             illegal;
    logic [WIDTH-1:0] result;
    logic [1:0]       dbg_state;

    modport master (
        output start, alucontrol, src_a, flush,
        input  busy, done, illegal, result, dbg_state
    );

    modport slave (
        input  start, alucontrol, src_a, flush,
        output busy, done, illegal, result, dbg_state
    );
endinterface

// File: rtl/custom_bitop_unit.sv
// Multi-cycle BITREV / POPCOUNT / CLZ unit that walks the operand STEP bits per cycle.
// Latency is fixed at WIDTH/STEP cycles; the FSM state is exported on dbg_state.
module custom_bitop_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    custom_bitop_unit_if.slave bus
);
    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_REV  = 2'd0,
        OP_POP  = 2'd1,
        OP_CLZ  = 2'd2,
        OP_NONE = 2'd3
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               found_q, found_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               illegal_q, illegal_d;

    op_e                dec_op;
    logic [STEP-1:0]    chunk_lo;
    logic [STEP-1:0]    chunk_hi;
    logic [STEP-1:0]    rev_chunk;
    logic [3:0]         pop_chunk;
    logic [3:0]         lz_chunk;
    logic               seen_one;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   opnd_step;
    logic               found_step;

    always_comb begin
        dec_op = OP_NONE;
        case (bus.alucontrol)
            4'b1001: dec_op = OP_REV;
            4'b1010: dec_op = OP_POP;
            4'b1011: dec_op = OP_CLZ;
            default: dec_op = OP_NONE;
        endcase
    end

    // Per-chunk primitives: BITREV/POPCOUNT consume the low end, CLZ the high end.
    always_comb begin
        chunk_lo  = opnd_q[STEP-1:0];
        chunk_hi  = opnd_q[WIDTH-1 -: STEP];
        rev_chunk = '0;
        pop_chunk = '0;
        lz_chunk  = '0;
        seen_one  = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            rev_chunk[STEP-1-i] = chunk_lo[i];
            pop_chunk           = pop_chunk + 4'(chunk_lo[i]);
        end
        for (int i = STEP - 1; i >= 0; i--) begin
            if (chunk_hi[i]) begin
                seen_one = 1'b1;
            end else if (!seen_one) begin
                lz_chunk = lz_chunk + 4'd1;
            end
        end
    end

    always_comb begin
        acc_step   = acc_q;
        opnd_step  = opnd_q;
        found_step = found_q;
        case (op_q)
            OP_REV: begin
                acc_step  = (acc_q << STEP) | WIDTH'(rev_chunk);
                opnd_step = opnd_q >> STEP;
            end
            OP_POP: begin
                acc_step  = acc_q + WIDTH'(pop_chunk);
                opnd_step = opnd_q >> STEP;
            end
            OP_CLZ: begin
                // Once a one has been seen the count is frozen; the walk still runs to N.
                acc_step   = found_q ? acc_q : acc_q + WIDTH'(lz_chunk);
                found_step = found_q | (|chunk_hi);
                opnd_step  = opnd_q << STEP;
            end
            default: begin
                acc_step = acc_q;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        count_d   = count_q;
        found_d   = found_q;
        result_d  = result_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start && !bus.flush) begin
                    if (dec_op != OP_NONE) begin
                        state_d = S_RUN;
                        op_d    = dec_op;
                        opnd_d  = bus.src_a;
                        acc_d   = '0;
                        count_d = '0;
                        found_d = 1'b0;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = acc_step;
                    opnd_d  = opnd_step;
                    found_d = found_step;
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_W'(N - 1)) begin
                        state_d  = S_DONE;
                        result_d = acc_step;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_REV;
            opnd_q    <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            found_q   <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            found_q   <= found_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.illegal   = illegal_q;
    assign bus.result    = result_q;
    assign bus.dbg_state = state_q;
endmodule
